// File: rtl/upstream_fcp_credit_tx_pkg.sv
// Shared types and helpers for the credit-gated upstream transmitter.
package upstream_fcp_credit_tx_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StCheck,
    StBlock,
    StSend
  } tx_state_e;

  localparam int unsigned VC_FIELD_LSB = 16;

  // Difference a - b reduced modulo 2^w; its bit w-1 is the sign of the wrapped distance.
  function automatic logic [63:0] wrap_diff(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/upstream_fcp_credit_tx_state_ram.sv
// Per-VC transmit and drained counters with init sweep, monotonic FCP write and bypassed read.
module fcp_credit_state_ram
  import upstream_fcp_credit_tx_pkg::*;
#(
  parameter int unsigned QUEUE_INDEX_WIDTH = 13,
  parameter int unsigned STAT_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fcp_en,
  input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  input  logic [STAT_WIDTH-1:0]        fcp_fccr,
  input  logic                         commit_en,
  input  logic [QUEUE_INDEX_WIDTH-1:0] commit_vc,
  input  logic [QUEUE_INDEX_WIDTH-1:0] rd_vc,
  output logic [STAT_WIDTH-1:0]        rd_tx_cnt,
  output logic [STAT_WIDTH-1:0]        rd_fccr,
  output logic                         init_done,
  output logic                         init_last
);

  localparam int unsigned NumVc = 2 ** QUEUE_INDEX_WIDTH;

  logic [STAT_WIDTH-1:0]        tx_cnt_mem [NumVc];
  logic [STAT_WIDTH-1:0]        fccr_mem   [NumVc];
  logic [QUEUE_INDEX_WIDTH-1:0] init_cnt_q;
  logic                         init_done_q;
  logic [STAT_WIDTH-1:0]        fccr_old;
  logic [STAT_WIDTH-1:0]        fccr_delta;
  logic                         fccr_fresh;

  always_comb begin
    fccr_old   = fccr_mem[fcp_vc];
    fccr_delta = STAT_WIDTH'(wrap_diff(64'(fcp_fccr), 64'(fccr_old), STAT_WIDTH));
    // Out-of-order or stale drain counts never move the stored value backwards.
    fccr_fresh = fcp_en && !fccr_delta[STAT_WIDTH-1];
    rd_fccr    = (fccr_fresh && (fcp_vc == rd_vc)) ? fcp_fccr : fccr_mem[rd_vc];
    rd_tx_cnt  = tx_cnt_mem[rd_vc];
  end

  assign init_last = !init_done_q && (init_cnt_q == '1);
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else if (!init_done_q) begin
      init_cnt_q <= init_cnt_q + QUEUE_INDEX_WIDTH'(1);
      if (init_last) begin
        init_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!init_done_q) begin
        tx_cnt_mem[init_cnt_q] <= '0;
        fccr_mem[init_cnt_q]   <= '0;
      end else begin
        if (fccr_fresh) begin
          fccr_mem[fcp_vc] <= fcp_fccr;
        end
        if (commit_en) begin
          tx_cnt_mem[commit_vc] <= tx_cnt_mem[commit_vc] + STAT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/upstream_fcp_credit_tx.sv
// Upstream transmitter: releases one-cell packets to the switch only when global credit
// (FCCL) and per-VC in-flight (FCCR) checks both pass.
module upstream_fcp_credit_tx
  import upstream_fcp_credit_tx_pkg::*;
#(
  parameter int unsigned QUEUE_INDEX_WIDTH = 13,
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned STAT_WIDTH        = 32,
  parameter int unsigned INIT_CREDIT       = 4096,
  parameter int unsigned VC_INFLIGHT_MAX   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
  input  logic                         s_axis_pkt_tvalid,
  output logic                         s_axis_pkt_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_pkt_tdata,
  output logic                         m_axis_pkt_tvalid,
  input  logic                         m_axis_pkt_tready,
  input  logic                         fcp_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  input  logic [STAT_WIDTH-1:0]        fcp_fccl,
  input  logic [STAT_WIDTH-1:0]        fcp_qlen,
  input  logic [STAT_WIDTH-1:0]        fcp_fccr,
  output logic                         init_done,
  output logic [STAT_WIDTH-1:0]        dbg_total_tx,
  output logic [STAT_WIDTH-1:0]        dbg_blocked_cycles,
  output logic [STAT_WIDTH-1:0]        dbg_last_qlen
);

  tx_state_e                    state_q, state_d;
  logic [STAT_WIDTH-1:0]        fccl_q;
  logic [STAT_WIDTH-1:0]        total_tx_q;
  logic [STAT_WIDTH-1:0]        blocked_q;
  logic [STAT_WIDTH-1:0]        last_qlen_q;
  logic [DATA_WIDTH-1:0]        pkt_data_q;
  logic [QUEUE_INDEX_WIDTH-1:0] pkt_vc_q;

  logic                  fcp_acc;
  logic                  fccl_fresh;
  logic                  commit;
  logic                  credit_ok;
  logic                  init_last;
  logic [STAT_WIDTH-1:0] fccl_delta;
  logic [STAT_WIDTH-1:0] fccl_eff;
  logic [STAT_WIDTH-1:0] g_diff;
  logic [STAT_WIDTH-1:0] v_diff;
  logic [STAT_WIDTH-1:0] rd_tx_cnt;
  logic [STAT_WIDTH-1:0] rd_fccr;

  fcp_credit_state_ram #(
    .QUEUE_INDEX_WIDTH (QUEUE_INDEX_WIDTH),
    .STAT_WIDTH        (STAT_WIDTH)
  ) u_state_ram (
    .clk       (clk),
    .rst       (rst),
    .fcp_en    (fcp_acc),
    .fcp_vc    (fcp_vc),
    .fcp_fccr  (fcp_fccr),
    .commit_en (commit),
    .commit_vc (pkt_vc_q),
    .rd_vc     (pkt_vc_q),
    .rd_tx_cnt (rd_tx_cnt),
    .rd_fccr   (rd_fccr),
    .init_done (init_done),
    .init_last (init_last)
  );

  always_comb begin
    fcp_acc    = fcp_valid && (state_q != StInit);
    fccl_delta = STAT_WIDTH'(wrap_diff(64'(fcp_fccl), 64'(fccl_q), STAT_WIDTH));
    fccl_fresh = fcp_acc && !fccl_delta[STAT_WIDTH-1];
    // A same-cycle credit update counts immediately so a blocked packet leaves one cycle later.
    fccl_eff   = fccl_fresh ? fcp_fccl : fccl_q;
    g_diff     = STAT_WIDTH'(wrap_diff(64'(fccl_eff), 64'(total_tx_q), STAT_WIDTH));
    v_diff     = rd_tx_cnt - rd_fccr;
    credit_ok  = !g_diff[STAT_WIDTH-1] && (g_diff != '0) &&
                 (v_diff < STAT_WIDTH'(VC_INFLIGHT_MAX));
  end

  always_comb begin
    state_d           = state_q;
    s_axis_pkt_tready = 1'b0;
    m_axis_pkt_tvalid = 1'b0;
    commit            = 1'b0;
    unique case (state_q)
      StInit: begin
        if (init_last) state_d = StIdle;
      end
      StIdle: begin
        s_axis_pkt_tready = 1'b1;
        if (s_axis_pkt_tvalid) state_d = StCheck;
      end
      StCheck: begin
        state_d = credit_ok ? StSend : StBlock;
      end
      StBlock: begin
        if (credit_ok) state_d = StSend;
      end
      StSend: begin
        m_axis_pkt_tvalid = 1'b1;
        if (m_axis_pkt_tready) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      fccl_q      <= STAT_WIDTH'(INIT_CREDIT);
      total_tx_q  <= '0;
      blocked_q   <= '0;
      last_qlen_q <= '0;
      pkt_data_q  <= '0;
      pkt_vc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fccl_fresh) fccl_q <= fcp_fccl;
      if (fcp_acc) last_qlen_q <= fcp_qlen;
      if ((state_q == StIdle) && s_axis_pkt_tvalid) begin
        pkt_data_q <= s_axis_pkt_tdata;
        pkt_vc_q   <= s_axis_pkt_tdata[VC_FIELD_LSB +: QUEUE_INDEX_WIDTH];
      end
      if (commit) total_tx_q <= total_tx_q + STAT_WIDTH'(1);
      if (state_q == StBlock) blocked_q <= blocked_q + STAT_WIDTH'(1);
    end
  end

  assign m_axis_pkt_tdata   = pkt_data_q;
  assign dbg_total_tx       = total_tx_q;
  assign dbg_blocked_cycles = blocked_q;
  assign dbg_last_qlen      = last_qlen_q;

endmodule
